// File: rtl/dem_pkg.sv
// Shared constants and types for the DEM element selector and its usage sorter.
package dem_pkg;
    localparam int N_ELEM = 18;
    localparam int IDX_W  = 5;
    localparam int PASS_W = 5;
    localparam logic [PASS_W-1:0] PASS_LAST = 5'd17;

    typedef enum logic {IDLE, SORT} state_t;

    localparam logic [N_ELEM-1:0][IDX_W-1:0] RESET_ORDER = {
        5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9,
        5'd8,  5'd7,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd0
    };
endpackage

// File: rtl/dem_cmp_swap.sv
// Compare-exchange cell: emits the index pair ordered by key, swapping only on strict greater.
module dem_cmp_swap
    import dem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [IDX_W-1:0] i_idx_a,
    input  logic [IDX_W-1:0] i_idx_b,
    input  logic [AW-1:0]    i_key_a,
    input  logic [AW-1:0]    i_key_b,
    output logic [IDX_W-1:0] o_idx_lo,
    output logic [IDX_W-1:0] o_idx_hi
);
    logic w_swap;

    // Equal keys stay in place so ties keep their previous order.
    assign w_swap   = (i_key_a > i_key_b);
    assign o_idx_lo = w_swap ? i_idx_b : i_idx_a;
    assign o_idx_hi = w_swap ? i_idx_a : i_idx_b;
endmodule

// File: rtl/dem_usage_sorter.sv
// Per-element usage accumulators with min-normalisation, plus an odd-even transposition
// sorter that delivers the least-used-first element order to the DEM selector.
module dem_usage_sorter
    import dem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             IN_VALID,
    input  logic [17:0]      SV,
    output logic             READY,
    output logic             OUT_VALID,
    output logic [IDX_W-1:0] SQ0,
    output logic [IDX_W-1:0] SQ1,
    output logic [IDX_W-1:0] SQ2,
    output logic [IDX_W-1:0] SQ3,
    output logic [IDX_W-1:0] SQ4,
    output logic [IDX_W-1:0] SQ5,
    output logic [IDX_W-1:0] SQ6,
    output logic [IDX_W-1:0] SQ7,
    output logic [IDX_W-1:0] SQ8,
    output logic [IDX_W-1:0] SQ9,
    output logic [IDX_W-1:0] SQ10,
    output logic [IDX_W-1:0] SQ11,
    output logic [IDX_W-1:0] SQ12,
    output logic [IDX_W-1:0] SQ13,
    output logic [IDX_W-1:0] SQ14,
    output logic [IDX_W-1:0] SQ15,
    output logic [IDX_W-1:0] SQ16,
    output logic [IDX_W-1:0] SQ17,
    output logic             OVERRUN
);
    localparam logic [AW:0] ACC_MAX = {1'b0, {AW{1'b1}}};

    logic [N_ELEM-1:0][AW-1:0]    r_acc;
    logic [N_ELEM-1:0][AW-1:0]    w_acc_next;
    logic [N_ELEM-1:0][IDX_W-1:0] r_list;
    logic [N_ELEM-1:0][IDX_W-1:0] w_list_next;
    logic [N_ELEM-1:0][IDX_W-1:0] r_sq;
    state_t                       r_state;
    logic [PASS_W-1:0]            r_pass;
    logic                         r_out_valid;
    logic                         r_overrun;
    logic [AW-1:0]                w_min;
    logic                         w_odd;
    logic [8:0][IDX_W-1:0]        w_a_idx;
    logic [8:0][IDX_W-1:0]        w_b_idx;
    logic [8:0][IDX_W-1:0]        w_lo;
    logic [8:0][IDX_W-1:0]        w_hi;

    // Head of the last sorted list is the minimum, so the subtraction cannot underflow.
    assign w_min = r_acc[r_list[0]];
    assign w_odd = r_pass[0];

    genvar gi;
    for (gi = 0; gi < N_ELEM; gi++) begin : g_acc
        logic [AW:0] w_sum;
        assign w_sum = {1'b0, r_acc[gi]} + {{AW{1'b0}}, SV[gi]} - {1'b0, w_min};
        assign w_acc_next[gi] = (w_sum > ACC_MAX) ? ACC_MAX[AW-1:0] : w_sum[AW-1:0];
    end

    genvar gk;
    for (gk = 0; gk < 9; gk++) begin : g_cs
        assign w_a_idx[gk] = w_odd ? r_list[2*gk+1] : r_list[2*gk];
        if (gk < 8) begin : g_mid
            assign w_b_idx[gk] = w_odd ? r_list[2*gk+2] : r_list[2*gk+1];
        end else begin : g_end
            assign w_b_idx[gk] = r_list[2*gk+1];
        end
        dem_cmp_swap #(.AW(AW)) u_cmp_swap (
            .i_idx_a  (w_a_idx[gk]),
            .i_idx_b  (w_b_idx[gk]),
            .i_key_a  (r_acc[w_a_idx[gk]]),
            .i_key_b  (r_acc[w_b_idx[gk]]),
            .o_idx_lo (w_lo[gk]),
            .o_idx_hi (w_hi[gk])
        );
    end

    // Odd passes leave both list ends untouched; the last cell idles.
    always_comb begin
        w_list_next = r_list;
        if (!w_odd) begin
            for (int k = 0; k < 9; k++) begin
                w_list_next[2*k]   = w_lo[k];
                w_list_next[2*k+1] = w_hi[k];
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                w_list_next[2*k+1] = w_lo[k];
                w_list_next[2*k+2] = w_hi[k];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc       <= '0;
            r_list      <= RESET_ORDER;
            r_sq        <= RESET_ORDER;
            r_state     <= IDLE;
            r_pass      <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (CLR) begin
            r_acc       <= '0;
            r_list      <= RESET_ORDER;
            r_sq        <= RESET_ORDER;
            r_state     <= IDLE;
            r_pass      <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_acc   <= w_acc_next;
                        r_pass  <= '0;
                        r_state <= SORT;
                    end
                end
                SORT: begin
                    r_list <= w_list_next;
                    if (IN_VALID) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_pass == PASS_LAST) begin
                        r_sq        <= w_list_next;
                        r_out_valid <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_pass <= r_pass + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign READY     = (r_state == IDLE);
    assign OUT_VALID = r_out_valid;
    assign OVERRUN   = r_overrun;
    assign SQ0  = r_sq[0];
    assign SQ1  = r_sq[1];
    assign SQ2  = r_sq[2];
    assign SQ3  = r_sq[3];
    assign SQ4  = r_sq[4];
    assign SQ5  = r_sq[5];
    assign SQ6  = r_sq[6];
    assign SQ7  = r_sq[7];
    assign SQ8  = r_sq[8];
    assign SQ9  = r_sq[9];
    assign SQ10 = r_sq[10];
    assign SQ11 = r_sq[11];
    assign SQ12 = r_sq[12];
    assign SQ13 = r_sq[13];
    assign SQ14 = r_sq[14];
    assign SQ15 = r_sq[15];
    assign SQ16 = r_sq[16];
    assign SQ17 = r_sq[17];
endmodule

// File: tb/tb_dem_usage_sorter.sv
// Scoreboard bench for dem_usage_sorter: a stable-sort reference model predicts SQ and usage.
module tb_dem_usage_sorter;
    logic        CLK = 1'b0;
    logic        RST;
    logic        CLR;
    logic        IN_VALID;
    logic [17:0] SV;
    logic        READY;
    logic        OUT_VALID;
    logic        OVERRUN;
    logic [4:0]  sq [18];

    dem_usage_sorter #(.AW(8)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .SV(SV),
        .READY(READY), .OUT_VALID(OUT_VALID),
        .SQ0(sq[0]),   .SQ1(sq[1]),   .SQ2(sq[2]),   .SQ3(sq[3]),   .SQ4(sq[4]),
        .SQ5(sq[5]),   .SQ6(sq[6]),   .SQ7(sq[7]),   .SQ8(sq[8]),   .SQ9(sq[9]),
        .SQ10(sq[10]), .SQ11(sq[11]), .SQ12(sq[12]), .SQ13(sq[13]), .SQ14(sq[14]),
        .SQ15(sq[15]), .SQ16(sq[16]), .SQ17(sq[17]),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [17:0][4:0] sq;
        logic [17:0][7:0] acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   m_acc  [18];
    int   m_list [18];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [17:0][4:0] dut_sq();
        logic [17:0][4:0] v;
        for (int k = 0; k < 18; k++) v[k] = sq[k];
        return v;
    endfunction

    function automatic logic [17:0][4:0] ident_sq();
        logic [17:0][4:0] v;
        for (int k = 0; k < 18; k++) v[k] = 5'(k);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 18; i++) begin
            m_acc[i]  = 0;
            m_list[i] = i;
        end
    endtask

    // Normalise against the current least-used element, clamp, then stable-sort the list.
    task automatic model_accept(input logic [17:0] sv);
        int   mn, v, key, j, tmp;
        exp_t e;
        mn = m_acc[m_list[0]];
        for (int i = 0; i < 18; i++) begin
            v = m_acc[i] + int'(sv[i]) - mn;
            m_acc[i] = (v > 255) ? 255 : v;
        end
        for (int i = 1; i < 18; i++) begin
            tmp = m_list[i];
            key = m_acc[tmp];
            j = i - 1;
            while (j >= 0 && m_acc[m_list[j]] > key) begin
                m_list[j+1] = m_list[j];
                j--;
            end
            m_list[j+1] = tmp;
        end
        for (int k = 0; k < 18; k++) begin
            e.sq[k]  = 5'(m_list[k]);
            e.acc[k] = 8'(m_acc[k]);
        end
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (!RST && OUT_VALID) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (dut_sq() !== mon_e.sq) begin
                    errors++;
                    $display("FAIL sq_order: got %h expected %h at %0t", dut_sq(), mon_e.sq, $time);
                end
                checks++;
                if (dut.r_acc !== mon_e.acc) begin
                    errors++;
                    $display("FAIL acc_bank: got %h expected %h at %0t", dut.r_acc, mon_e.acc, $time);
                end
            end
        end
    end

    task automatic do_reset();
        RST = 1'b1; CLR = 1'b0; IN_VALID = 1'b0; SV = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        model_reset();
    endtask

    // One sample; optional overrun strobe n edges after the accept edge (0 = none).
    task automatic accept(input logic [17:0] sv, input int strobe_at);
        int lat;
        bit ready_bad;
        @(negedge CLK);
        check("ready_before_accept", READY, 1);
        IN_VALID = 1'b1;
        SV = sv;
        model_accept(sv);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        SV = 18'($urandom);
        lat = -1;
        ready_bad = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLK);
            #1;
            IN_VALID = 1'b0;
            if (OUT_VALID) begin
                lat = n;
                break;
            end
            if (READY) ready_bad = 1'b1;
            if (n == strobe_at) IN_VALID = 1'b1;
        end
        IN_VALID = 1'b0;
        check("latency", lat, 18);
        check("ready_low_during_sort", ready_bad, 0);
        check("ready_after_out", READY, 1);
    endtask

    task automatic abort_setup();
        @(negedge CLK);
        IN_VALID = 1'b1;
        SV = 18'($urandom);
        model_accept(SV);
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1 IN_VALID = 1'b1;
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        check("overrun_before_abort", OVERRUN, 1);
        repeat (4) @(posedge CLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        do_reset();
        check("reset_ready", READY, 1);
        check("reset_out_valid", OUT_VALID, 0);
        check("reset_overrun", OVERRUN, 0);
        check("reset_sq", dut_sq(), ident_sq());

        accept(18'h00001, 0);
        check("single_sq17", sq[17], 0);
        check("single_sq0", sq[0], 1);
        accept(18'h3FFFE, 0);
        check("tie_sq0", sq[0], 1);
        accept(18'h00000, 0);
        check("overrun_clean", OVERRUN, 0);

        do_reset();
        for (int s = 0; s < 300; s++) accept(18'h00001, 0);
        check("sat_acc0", dut.r_acc[0], 255);
        check("sat_sq17", sq[17], 0);

        do_reset();
        for (int s = 0; s < 17; s++) accept((18'h1 << (17 - s)) - 18'h1, 0);
        accept(18'h00000, 0);
        for (int k = 0; k < 18; k++) check("reversal_sq", sq[k], 17 - k);

        do_reset();
        accept(18'h2A5C3, 5);
        check("overrun_set", OVERRUN, 1);
        accept(18'h15A3C, 0);
        check("overrun_sticky", OVERRUN, 1);

        do_reset();
        abort_setup();
        CLR = 1'b1;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        IN_VALID = 1'b0;
        exp_q.delete();
        model_reset();
        check("clr_ready", READY, 1);
        check("clr_overrun", OVERRUN, 0);
        check("clr_sq", dut_sq(), ident_sq());
        check("clr_acc", dut.r_acc, 0);
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge CLK);
            #1 if (OUT_VALID) seen++;
        end
        check("clr_no_out_valid", seen, 0);
        check("clr_ready_hold", READY, 1);

        do_reset();
        abort_setup();
        #2 RST = 1'b1;
        #1;
        check("rst_ready", READY, 1);
        check("rst_overrun", OVERRUN, 0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_sq", dut_sq(), ident_sq());
        check("rst_acc", dut.r_acc, 0);
        @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        model_reset();
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge CLK);
            #1 if (OUT_VALID) seen++;
        end
        check("rst_no_out_valid", seen, 0);

        do_reset();
        for (int s = 0; s < 60; s++) begin
            accept(18'($urandom), (s % 5 == 4) ? int'($urandom_range(2, 15)) : 0);
        end
        check("random_overrun", OVERRUN, 1);

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
